// File: rtl/fir_cap_pkg.sv
// Shared types and constants for the FIR output capture stage.
package fir_cap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

    localparam int SAT_CNT_W = 8;
    localparam logic [SAT_CNT_W-1:0] SAT_CNT_MAX = '1;

    // Address width for a DEPTH-entry buffer; never narrower than one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fir_output_capture_if.sv
// Sample stream, status and readout port bundle for fir_output_capture.
interface fir_output_capture_if
    import fir_cap_pkg::*;
#(
    parameter int N     = 32,
    parameter int OUT_W = 16,
    parameter int DEPTH = 64
);
    localparam int AW = addr_w(DEPTH);

    logic                 start;
    logic                 in_valid;
    logic [N-1:0]         in_data;
    logic                 busy;
    logic                 done;
    logic [SAT_CNT_W-1:0] sat_cnt;
    logic                 rd_en;
    logic [AW-1:0]        rd_addr;
    logic [OUT_W-1:0]     rd_data;
    logic                 rd_valid;

    modport master (
        output start, in_valid, in_data, rd_en, rd_addr,
        input  busy, done, sat_cnt, rd_data, rd_valid
    );

    modport slave (
        input  start, in_valid, in_data, rd_en, rd_addr,
        output busy, done, sat_cnt, rd_data, rd_valid
    );

endinterface

// File: rtl/fir_cap_ram.sv
// Capture buffer: DEPTH x OUT_W simple dual-port memory with a registered read port.
// A read and a write to the same address on one edge returns the previous contents.
module fir_cap_ram
    import fir_cap_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int OUT_W = 16,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [OUT_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [OUT_W-1:0] rd_data,
    output logic             rd_valid
);

    logic [OUT_W-1:0] mem [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/fir_output_capture.sv
// Drops the FIR warm-up samples, rescales the rest by >>SHIFT and captures DEPTH results.
// Build option FIR_CAP_SATURATE_EN: clamp out-of-range samples and count them in sat_cnt.
module fir_output_capture
    import fir_cap_pkg::*;
#(
    parameter int N     = 32,
    parameter int TAPS  = 4,
    parameter int SHIFT = 7,
    parameter int OUT_W = 16,
    parameter int DEPTH = 64
) (
    input logic                clk,
    input logic                reset,
    fir_output_capture_if.slave bus
);

    // state   | meaning
    // IDLE    | waiting for start, buffer contents untouched
    // WARMUP  | discarding the first TAPS-1 filter outputs
    // CAPTURE | writing rescaled samples to the buffer
    // DONE    | buffer full, done held until start or reset

    localparam int AW     = addr_w(DEPTH);
    localparam int SKIP_W = (TAPS > 1) ? $clog2(TAPS) : 1;

    cap_state_t        state;
    logic [SKIP_W-1:0] skip_cnt;
    logic [AW-1:0]     wr_ptr;
    logic              busy_r;
    logic              done_r;
    logic              we;
    logic [OUT_W-1:0]  wr_data;
    logic              start_ok;

    assign start_ok = bus.start && ((state == IDLE) || (state == DONE));
    assign we       = !reset && (state == CAPTURE) && bus.in_valid;

`ifdef FIR_CAP_SATURATE_EN
    logic                 over;
    logic [SAT_CNT_W-1:0] sat_cnt_r;

    // Any bit above the stored window after the shift means the sample is out of range.
    always_comb begin
        over    = |(N'(bus.in_data) >> (SHIFT + OUT_W));
        wr_data = over ? '1 : OUT_W'(N'(bus.in_data) >> SHIFT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_cnt_r <= '0;
        end else if (start_ok) begin
            sat_cnt_r <= '0;
        end else if (we && over && (sat_cnt_r != SAT_CNT_MAX)) begin
            sat_cnt_r <= sat_cnt_r + 1'b1;
        end
    end

    assign bus.sat_cnt = sat_cnt_r;
`else
    assign wr_data     = OUT_W'(N'(bus.in_data) >> SHIFT);
    assign bus.sat_cnt = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            skip_cnt <= '0;
            wr_ptr   <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        skip_cnt <= SKIP_W'(TAPS - 1);
                        wr_ptr   <= '0;
                        busy_r   <= 1'b1;
                        done_r   <= 1'b0;
                        state    <= (TAPS == 1) ? CAPTURE : WARMUP;
                    end
                end
                WARMUP: begin
                    if (bus.in_valid) begin
                        skip_cnt <= skip_cnt - 1'b1;
                        if (skip_cnt == SKIP_W'(1)) begin
                            state <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (bus.in_valid) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (wr_ptr == AW'(DEPTH - 1)) begin
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;

    fir_cap_ram #(
        .DEPTH (DEPTH),
        .OUT_W (OUT_W),
        .AW    (AW)
    ) u_ram (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .wr_addr  (wr_ptr),
        .wr_data  (wr_data),
        .rd_en    (bus.rd_en),
        .rd_addr  (bus.rd_addr),
        .rd_data  (bus.rd_data),
        .rd_valid (bus.rd_valid)
    );

endmodule

// File: tb/tb_fir_output_capture.sv
// Self-checking bench for fir_output_capture: sample-count model plus pinned literal scenarios.
module tb_fir_output_capture;
    import fir_cap_pkg::*;

    localparam int N     = 32;
    localparam int TAPS  = 4;
    localparam int SHIFT = 7;
    localparam int OUT_W = 16;
    localparam int DEPTH = 64;
    localparam int AW    = addr_w(DEPTH);
`ifdef FIR_CAP_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fir_output_capture_if #(.N(N), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

    fir_output_capture #(
        .N(N), .TAPS(TAPS), .SHIFT(SHIFT), .OUT_W(OUT_W), .DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model: a capture is "number of valid samples accepted since start"; the first
    // TAPS-1 are dropped, sample TAPS+i lands in entry i, entry DEPTH-1 ends it.
    bit               m_active = 0;
    bit               m_done = 0;
    int               m_acc = 0;
    int               m_sat = 0;
    bit               m_rd_valid = 0;
    bit               m_rd_known = 1;
    logic [OUT_W-1:0] m_rd_data = '0;
    logic [OUT_W-1:0] m_buf [DEPTH];
    bit               m_known [DEPTH];

    initial begin
        int idx;
        logic [N-1:0] shifted;
        logic [OUT_W-1:0] val;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_active = 0; m_done = 0; m_acc = 0; m_sat = 0;
                m_rd_valid = 0; m_rd_known = 1; m_rd_data = '0;
                foreach (m_known[i]) m_known[i] = 0;
            end else begin
                if (bus.rd_en) begin
                    m_rd_valid = 1;
                    m_rd_known = m_known[bus.rd_addr];
                    m_rd_data  = m_buf[bus.rd_addr];
                end else begin
                    m_rd_valid = 0;
                end
                if (!m_active) begin
                    if (bus.start) begin
                        m_active = 1; m_done = 0; m_acc = 0; m_sat = 0;
                    end
                end else if (bus.in_valid) begin
                    m_acc++;
                    if (m_acc >= TAPS) begin
                        idx = m_acc - TAPS;
                        shifted = bus.in_data >> SHIFT;
                        if (SAT_EN && shifted > N'(65535)) begin
                            val = 16'hFFFF;
                            if (m_sat < 255) m_sat++;
                        end else begin
                            val = shifted[OUT_W-1:0];
                        end
                        m_buf[idx] = val;
                        m_known[idx] = 1;
                        if (idx == DEPTH - 1) begin
                            m_active = 0; m_done = 1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("busy", longint'(bus.busy), longint'(m_active));
                check("done", longint'(bus.done), longint'(m_done));
                check("sat_cnt", longint'(bus.sat_cnt), SAT_EN ? longint'(m_sat) : 0);
                check("rd_valid", longint'(bus.rd_valid), longint'(m_rd_valid));
                if (m_rd_known) check("rd_data", longint'(bus.rd_data), longint'(m_rd_data));
            end
        end
    end

    task automatic drive(input logic s, input logic v, input logic [N-1:0] d,
                         input logic re, input logic [AW-1:0] ra);
        bus.start = s; bus.in_valid = v; bus.in_data = d;
        bus.rd_en = re; bus.rd_addr = ra;
        @(negedge clk);
    endtask

    task automatic read_block(input string nm, input int base, input int inc);
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, '0, 1, AW'(i));
            check({nm, "_rd_valid"}, longint'(bus.rd_valid), 1);
            check({nm, "_entry"}, longint'(bus.rd_data), longint'(16'(base + inc * i)));
        end
        drive(0, 0, '0, 0, '0);
        check({nm, "_rd_valid_drop"}, longint'(bus.rd_valid), 0);
        check({nm, "_rd_hold"}, longint'(bus.rd_data), longint'(16'(base + inc * (DEPTH - 1))));
    endtask

    initial begin
        int busy_cnt;
        int nvalid;
        logic s, v, re;
        logic [N-1:0] d;
        logic [N-1:0] first_cap;

        bus.start = 0; bus.in_valid = 0; bus.in_data = '0; bus.rd_en = 0; bus.rd_addr = '0;
        @(negedge clk);
        drive(0, 0, '0, 0, '0);
        drive(0, 1, 32'h1234, 1, '0);
        chk_en = 1'b1;
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_done", longint'(bus.done), 0);
        check("rst_sat", longint'(bus.sat_cnt), 0);
        check("rst_rd_valid", longint'(bus.rd_valid), 0);
        check("rst_rd_data", longint'(bus.rd_data), 0);
        reset = 1'b0;
        drive(0, 1, 32'h5555, 0, '0);
        check("idle_ignores_valid", longint'(bus.busy), 0);

        // Ramp, back-to-back
        busy_cnt = 0;
        drive(1, 1, 32'hFFFF_FFFF, 0, '0);
        if (bus.busy) busy_cnt++;
        for (int k = 0; k < TAPS - 1 + DEPTH; k++) begin
            drive(0, 1, N'(k * 128), 1, (k >= 3) ? AW'(k - 3) : '0);
            if (bus.busy) busy_cnt++;
        end
        check("ramp_done", longint'(bus.done), 1);
        drive(0, 0, '0, 0, '0);
        if (bus.busy) busy_cnt++;
        check("ramp_busy_cycles", busy_cnt, 67);
        read_block("ramp", 3, 1);

        // Constant 12800, random gaps, read at the write address, start pulses mid-capture
        drive(1, 0, '0, 0, '0);
        nvalid = 0;
        for (int it = 0; it < 2000 && nvalid < 67; it++) begin
            v = ($urandom_range(0, 2) != 0);
            s = (nvalid > 5 && nvalid < 60 && $urandom_range(0, 9) == 0);
            drive(s, v, N'(12800), 1, (nvalid >= 3) ? AW'(nvalid - 3) : '0);
            if (v) nvalid++;
        end
        check("golden_complete", nvalid, 67);
        check("golden_done", longint'(bus.done), 1);
        read_block("golden", 100, 0);

        // Overflow
        drive(1, 0, '0, 0, '0);
        for (int k = 0; k < 67; k++) drive(0, 1, 32'h0080_0000, 0, '0);
        check("ovf_done", longint'(bus.done), 1);
        check("ovf_sat_cnt", longint'(bus.sat_cnt), SAT_EN ? 64 : 0);
        read_block("ovf", SAT_EN ? 32'hFFFF : 0, 0);

        // Ramp with in_valid every other cycle
        busy_cnt = 0;
        drive(1, 0, '0, 0, '0);
        if (bus.busy) busy_cnt++;
        for (int k = 0; k < 67; k++) begin
            drive(0, 0, 32'hABCD_0000, 0, '0);
            if (bus.busy) busy_cnt++;
            drive(0, 1, N'(k * 128), 0, '0);
            if (bus.busy) busy_cnt++;
        end
        check("alt_done", longint'(bus.done), 1);
        check("alt_busy_cycles", busy_cnt, 134);
        read_block("alt", 3, 1);

        // Reset after 10 captured samples
        drive(1, 0, '0, 0, '0);
        for (int k = 0; k < 13; k++) drive(0, 1, 32'h0080_0000, 0, '0);
        check("pre_rst_busy", longint'(bus.busy), 1);
        check("pre_rst_sat", longint'(bus.sat_cnt), SAT_EN ? 10 : 0);
        reset = 1'b1;
        drive(0, 1, 32'h0080_0000, 0, '0);
        reset = 1'b0;
        check("abort_busy", longint'(bus.busy), 0);
        check("abort_done", longint'(bus.done), 0);
        check("abort_sat", longint'(bus.sat_cnt), 0);
        drive(1, 0, '0, 0, '0);
        for (int k = 0; k < 67; k++) drive(0, 1, N'((k + 1000) * 128), 0, '0);
        read_block("rst_ramp", 1003, 1);

        // Start while DONE restarts from address 0
        check("pre_restart_done", longint'(bus.done), 1);
        drive(1, 1, 32'hDEAD_BEEF, 0, '0);
        check("restart_done_clr", longint'(bus.done), 0);
        check("restart_busy", longint'(bus.busy), 1);
        nvalid = 0;
        first_cap = '0;
        for (int it = 0; it < 2000 && nvalid < 67; it++) begin
            v = $urandom_range(0, 1) == 1;
            d = N'($urandom_range(0, 32'h007F_FFFF));
            drive(0, v, d, $urandom_range(0, 1) == 1, AW'($urandom_range(0, DEPTH - 1)));
            if (v) begin
                if (nvalid == 3) first_cap = d;
                nvalid++;
            end
        end
        check("restart_complete", nvalid, 67);
        drive(0, 0, '0, 1, '0);
        check("restart_entry0", longint'(bus.rd_data), longint'(first_cap >> 7));

        // Random traffic against the model
        for (int it = 0; it < 3000; it++) begin
            s  = $urandom_range(0, 39) == 0;
            v  = $urandom_range(0, 1) == 1;
            re = $urandom_range(0, 1) == 1;
            d  = ($urandom_range(0, 3) == 0) ? N'($urandom()) : N'($urandom_range(0, 32'h007F_FFFF));
            reset = ($urandom_range(0, 499) == 0);
            drive(s, v, d, re, AW'($urandom_range(0, DEPTH - 1)));
        end
        reset = 1'b0;
        drive(0, 0, '0, 0, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fir_output_capture.md
# fir_output_capture

Downstream stage of the parallel FIR filter: consumes the filter's `data_out` stream, discards the first TAPS-1 warm-up samples, rescales each remaining sample by a fixed right shift, and stores DEPTH results in an internal capture buffer. The buffer is exposed through a registered read port for the fitness-evaluation readout. It replaces ad-hoc warm-up skipping in the fitness flow with a deterministic hardware window.

## Interface
- `N`, 32, input sample width (matches the FIR output width)
- `TAPS`, 4, number of filter taps; TAPS-1 leading samples are discarded
- `SHIFT`, 7, right-shift applied to each sample (coefficient sum 0x80 gives unity gain)
- `OUT_W`, 16, stored sample width
- `DEPTH`, 64, capture length; power of two, ≥2
- `clk`  in  1  clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin a capture (IDLE or DONE only)
- `in_valid`  in  1  `in_data` carries a filter output this cycle
- `in_data`  in  N  filter output, unsigned
- `busy`  out  1  capture in progress (WARMUP or CAPTURE)
- `done`  out  1  buffer full; held until next `start` or `reset`
- `sat_cnt`  out  8  number of saturated samples this capture, sticks at 255
- `rd_en`  in  1  read request
- `rd_addr`  in  log2(DEPTH)  read address
- `rd_data`  out  OUT_W  read data
- `rd_valid`  out  1  `rd_data` valid

## Operation
- States: IDLE, WARMUP, CAPTURE, DONE. Reset → IDLE; `busy`, `done`, `sat_cnt`, `rd_data`, `rd_valid`, write pointer, skip counter all 0. Buffer contents are not reset.
- IDLE/DONE + `start` → WARMUP with skip counter = TAPS-1, write pointer = 0, `sat_cnt` = 0, `done` = 0. If TAPS = 1, go directly to CAPTURE.
- `start` in WARMUP or CAPTURE is ignored.
- `in_valid` in IDLE or DONE is ignored, including in the same cycle as `start`.
- WARMUP: each `in_valid` decrements the skip counter and discards the sample. The transition to CAPTURE happens on the edge that consumes the last skipped sample.
- CAPTURE: each `in_valid` computes `in_data >> SHIFT` (logical shift). The value is written to `buf[wr_ptr]` and `wr_ptr` increments. The write of entry DEPTH-1 moves the FSM to DONE.
- Width rule: the shifted value has N-SHIFT bits. If it exceeds 2^OUT_W-1, handling follows the Configuration section.
- Read port: operates in every state. `rd_en` at edge k gives `rd_data = buf[rd_addr]` and `rd_valid = 1` after edge k. `rd_valid` drops to 0 after any edge without `rd_en`; `rd_data` then holds its value. A read and a write to the same address in the same cycle returns the old data.
- `reset` mid-capture aborts immediately and returns to IDLE. Partially written entries remain in the buffer but are undefined for use.

## Timing
- `busy` rises the cycle after the `start` edge. It falls, and `done` rises, the cycle after the edge accepting the DEPTH-th captured sample.
- With back-to-back `in_valid`, a capture completes in TAPS-1+DEPTH accepted samples. Gaps in `in_valid` only stretch the capture.
- Read latency is 1 cycle. Back-to-back reads give one result per cycle.
- `sat_cnt` updates on the same edge as the corresponding write.

## Configuration
- `FIR_CAP_SATURATE_EN` defined: out-of-range values are clamped to 2^OUT_W-1, and `sat_cnt` increments (saturating at 255).
- Not defined: the low OUT_W bits of the shifted value are stored (wrap-around), and `sat_cnt` is constant 0.

## Structure
- Package `fir_cap_pkg`: state enum typedef (IDLE/WARMUP/CAPTURE/DONE), the `sat_cnt` width constant, and an address-width function of DEPTH.
- Sub-module `fir_cap_ram`: simple dual-port memory, DEPTH×OUT_W, one write port and one registered read port with old-data-on-collision behaviour.

## Test plan
- Ramp: defaults, `start`, then `in_data` = k·128 for k = 0..66 back-to-back → `buf[i]` = i+3 for i = 0..63, `done` = 1 after the 67th sample, `busy` high for exactly 67 cycles.
- Golden moving-average: constant filter output 12800 (input 100, coefficients 0x20) → all 64 entries read back as 100, with `rd_valid` one cycle after each `rd_en`.
- Overflow: `in_data` = 0x00800000 (shifted value 0x10000) → with the macro, entries = 0xFFFF and `sat_cnt` = 64; without it, entries = 0x0000 and `sat_cnt` = 0.
- `in_valid` asserted every other cycle, ramp as above → identical buffer contents; completion takes twice as many cycles.
- `reset` after 10 captured samples → `busy`/`done`/`sat_cnt` read 0 the next cycle. A new `start` re-skips 3 samples and writes from address 0.
- `start` pulsed during CAPTURE → no effect. `start` in DONE → `done` clears the next cycle and a new capture overwrites entries from address 0.
